// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants and types for the key event encoder path.
package ps2_pkg;

  localparam logic [7:0] SC_EXTENDED = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_BREAK,
    ST_CODE
  } enc_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead synchronous FIFO of queued key events; head is visible on dout while not empty.
module key_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  key_event_t       din,
  output key_event_t       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  key_event_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_break_encoder.sv
// Turns make/break key events into PS/2 set-2 scan code bytes (1-3 bytes per event).
module key_break_encoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             global_clk,
  input  logic             global_rst_n,
  input  logic [15:0]      key_in,
  input  logic             key_break_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             err_reserved
);

  enc_state_t state;
  key_event_t cur;
  key_event_t push_ev;
  key_event_t head;
  logic       ready_en;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept_c;
  logic       reserved_c;
  logic       push_c;
  logic       pop_c;
  logic       fire_c;
  enc_state_t first_state;
  logic [7:0] first_byte;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (global_clk),
    .rst_n (global_rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (push_ev),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ready_en keeps key_ready low through reset and releases it one edge later.
  assign key_ready = ready_en && !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  always_comb begin
    accept_c    = key_valid && key_ready;
    reserved_c  = (key_in[7:0] == SC_EXTENDED) || (key_in[7:0] == SC_BREAK);
    push_c      = accept_c && !reserved_c;
    push_ev     = '{ext: (key_in[15:8] == SC_EXTENDED), brk: key_break_in, code: key_in[7:0]};
    fire_c      = byte_valid && byte_ready;
    pop_c       = !fifo_empty && ((state == ST_IDLE) || ((state == ST_CODE) && fire_c));
    first_state = ST_CODE;
    first_byte  = head.code;
    if (head.ext) begin
      first_state = ST_PREFIX;
      first_byte  = SC_EXTENDED;
    end else if (head.brk) begin
      first_state = ST_BREAK;
      first_byte  = SC_BREAK;
    end
  end

  // Sequencer: a pop loads the next event, otherwise advance on each byte handshake.
  always_ff @(posedge global_clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state        <= ST_IDLE;
      cur          <= '0;
      byte_out     <= '0;
      byte_valid   <= 1'b0;
      err_reserved <= 1'b0;
      ready_en     <= 1'b0;
    end else begin
      ready_en     <= 1'b1;
      err_reserved <= accept_c && reserved_c;
      if (pop_c) begin
        cur        <= head;
        state      <= first_state;
        byte_out   <= first_byte;
        byte_valid <= 1'b1;
      end else if (fire_c) begin
        case (state)
          ST_PREFIX: begin
            state    <= cur.brk ? ST_BREAK : ST_CODE;
            byte_out <= cur.brk ? SC_BREAK : cur.code;
          end
          ST_BREAK: begin
            state    <= ST_CODE;
            byte_out <= cur.code;
          end
          ST_CODE: begin
            state      <= ST_IDLE;
            byte_valid <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_break_encoder.sv
// Directed self-checking bench for key_break_encoder.
module tb_key_break_encoder;

  logic        global_clk = 1'b0;
  logic        global_rst_n;
  logic [15:0] key_in;
  logic        key_break_in;
  logic        key_valid;
  logic        key_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        err_reserved;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] got_q [$];

  key_break_encoder #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .global_clk   (global_clk),
    .global_rst_n (global_rst_n),
    .key_in       (key_in),
    .key_break_in (key_break_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .err_reserved (err_reserved)
  );

  always #5 global_clk = ~global_clk;

  // Record every byte the consumer takes.
  always @(posedge global_clk) begin
    if (global_rst_n && byte_valid && byte_ready) got_q.push_back(byte_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge global_clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] k, input logic b);
    key_in       = k;
    key_break_in = b;
    key_valid    = 1'b1;
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp [$]);
    logic [7:0] g;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 8'h00;
      check($sformatf("%s_b%0d", tag, i), 32'(g), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] exp_q [$];
    global_rst_n = 1'b0;
    key_in       = '0;
    key_break_in = 1'b0;
    key_valid    = 1'b0;
    byte_ready   = 1'b1;

    // Reset values
    tick(); tick();
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_byte_out", 32'(byte_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_err", 32'(err_reserved), 0);
    check("rst_key_ready", 32'(key_ready), 0);
    global_rst_n = 1'b1;
    #1;
    check("rel_key_ready_pre", 32'(key_ready), 0);
    tick();
    check("rel_key_ready", 32'(key_ready), 1);

    // Make normal: single byte 1C two edges after accept
    offer(16'h001C, 1'b0);
    tick();
    key_valid = 1'b0;
    check("mk_lat_valid0", 32'(byte_valid), 0);
    check("mk_busy", 32'(busy), 1);
    tick();
    check("mk_valid", 32'(byte_valid), 1);
    check("mk_byte", 32'(byte_out), 32'h1C);
    tick();
    check("mk_valid_drop", 32'(byte_valid), 0);
    check("mk_idle", 32'(busy), 0);

    // Break extended then break normal, back-to-back with no bubble
    offer(16'hE075, 1'b1);
    tick();
    offer(16'h001C, 1'b1);
    tick();
    key_valid = 1'b0;
    check("bx_v0", 32'(byte_valid), 1);
    check("bx_b0", 32'(byte_out), 32'hE0);
    tick();
    check("bx_v1", 32'(byte_valid), 1);
    check("bx_b1", 32'(byte_out), 32'hF0);
    tick();
    check("bx_v2", 32'(byte_valid), 1);
    check("bx_b2", 32'(byte_out), 32'h75);
    tick();
    check("bx_v3", 32'(byte_valid), 1);
    check("bx_b3", 32'(byte_out), 32'hF0);
    tick();
    check("bx_v4", 32'(byte_valid), 1);
    check("bx_b4", 32'(byte_out), 32'h1C);
    tick();
    check("bx_end", 32'(byte_valid), 0);

    // Backpressure on the F0 of a break
    byte_ready = 1'b0;
    offer(16'h001C, 1'b1);
    tick();
    key_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_v%0d", i), 32'(byte_valid), 1);
      check($sformatf("bp_hold_b%0d", i), 32'(byte_out), 32'hF0);
      tick();
    end
    byte_ready = 1'b1;
    tick();
    check("bp_resume_v", 32'(byte_valid), 1);
    check("bp_resume_b", 32'(byte_out), 32'h1C);
    tick();
    check("bp_end", 32'(byte_valid), 0);

    // Fill the FIFO while the consumer stalls
    byte_ready = 1'b0;
    got_q.delete();
    offer(16'h0015, 1'b0); tick();
    offer(16'hE06B, 1'b0); tick();
    offer(16'h0029, 1'b1); tick();
    offer(16'hE074, 1'b1); tick();
    offer(16'h005A, 1'b0); tick();
    check("fill_ready", 32'(key_ready), 0);
    check("fill_count", 32'(fifo_count), 4);
    check("fill_head", 32'(byte_out), 32'h15);
    offer(16'h0033, 1'b0); tick();
    check("fill_no_overwrite", 32'(fifo_count), 4);
    key_valid  = 1'b0;
    byte_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    exp_q = '{8'h15, 8'hE0, 8'h6B, 8'hF0, 8'h29, 8'hE0, 8'hF0, 8'h74, 8'h5A};
    check_stream("fill", exp_q);
    check("fill_drained", 32'(busy), 0);

    // Reserved code is dropped with a one-cycle error pulse
    got_q.delete();
    offer(16'h00F0, 1'b0);
    tick();
    key_valid = 1'b0;
    check("rsv_err", 32'(err_reserved), 1);
    check("rsv_count", 32'(fifo_count), 0);
    tick();
    check("rsv_err_clear", 32'(err_reserved), 0);
    check("rsv_no_byte", 32'(byte_valid), 0);
    tick();
    check("rsv_stream", 32'(got_q.size()), 0);

    // Unknown high byte treated as non-extended
    offer(16'h121C, 1'b0);
    tick();
    key_valid = 1'b0;
    tick();
    check("hi_v", 32'(byte_valid), 1);
    check("hi_b", 32'(byte_out), 32'h1C);
    tick();
    check("hi_end", 32'(byte_valid), 0);

    // Reset in the middle of a sequence with events queued
    byte_ready = 1'b0;
    offer(16'hE070, 1'b1); tick();
    offer(16'h0011, 1'b0); tick();
    offer(16'h0022, 1'b0); tick();
    key_valid = 1'b0;
    check("mid_b", 32'(byte_out), 32'hE0);
    check("mid_count", 32'(fifo_count), 2);
    global_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(byte_valid), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    tick(); tick();
    global_rst_n = 1'b1;
    byte_ready   = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", 32'(busy), 0);
    check("mid_count_after", 32'(fifo_count), 0);
    check("mid_no_bytes", 32'(got_q.size()), 0);
    offer(16'h001C, 1'b0);
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    exp_q = '{8'h1C};
    check_stream("mid_new", exp_q);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
